// File: rtl/mix_columns_engine.sv
// AES MixColumns / InvMixColumns engine with valid/ready handshake.
// Transforms COLS_PER_CYCLE columns per beat from a captured working copy of the state.

module mc_col (
  input  logic [31:0] i_col,
  input  logic        i_inv,
  output logic [31:0] o_col
);
  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  logic [7:0] w_a [4];

  for (genvar r = 0; r < 4; r++) begin : g_byte
    assign w_a[r] = i_col[31-8*r -: 8];
  end

  // Each row is row 0 applied to the column bytes rotated up by r.
  for (genvar r = 0; r < 4; r++) begin : g_row
    logic [7:0] w_p [4];
    logic [7:0] w_x2 [4];
    logic [7:0] w_x4 [4];
    logic [7:0] w_x8 [4];
    logic [7:0] w_fwd, w_inv;

    always_comb begin
      for (int k = 0; k < 4; k++) begin
        w_p[k]  = w_a[(r+k)%4];
        w_x2[k] = xt(w_p[k]);
        w_x4[k] = xt(w_x2[k]);
        w_x8[k] = xt(w_x4[k]);
      end
      w_fwd = w_x2[0] ^ (w_x2[1] ^ w_p[1]) ^ w_p[2] ^ w_p[3];
      w_inv = (w_x8[0] ^ w_x4[0] ^ w_x2[0]) ^ (w_x8[1] ^ w_x2[1] ^ w_p[1]) ^
              (w_x8[2] ^ w_x4[2] ^ w_p[2]) ^ (w_x8[3] ^ w_p[3]);
    end

    assign o_col[31-8*r -: 8] = i_inv ? w_inv : w_fwd;
  end
endmodule

module mix_columns_engine #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic         in_inverse,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);
  if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cfg
    $fatal(1, "mix_columns_engine: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  localparam int         BEATS = 4 / COLS_PER_CYCLE;
  localparam logic [1:0] LAST  = 2'(BEATS - 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2} state_t;

  state_t                         r_state, w_next;
  logic [1:0]                     r_beat;
  logic [127:0]                   r_work, r_out;
  logic                           r_inv, r_live, r_out_vld, r_busy;
  logic                           w_accept;
  logic [COLS_PER_CYCLE-1:0][31:0] w_col, w_res;

  // r_live keeps in_ready low while reset is asserted and until the first edge after release.
  assign in_ready  = r_live && (r_state == S_IDLE || (r_state == S_DONE && out_ready));
  assign w_accept  = in_valid && in_ready && !flush;
  assign out_valid = r_out_vld;
  assign busy      = r_busy;
  assign out_state = r_out;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_BUSY;
      S_BUSY:  if (r_beat == LAST) w_next = S_DONE;
      S_DONE:  if (out_ready) w_next = w_accept ? S_BUSY : S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (flush) w_next = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    for (int j = 0; j < COLS_PER_CYCLE; j++)
      w_col[j] = r_work[(int'(r_beat)*COLS_PER_CYCLE + j)*32 +: 32];
  end

  for (genvar j = 0; j < COLS_PER_CYCLE; j++) begin : g_col
    mc_col u_col (.i_col(w_col[j]), .i_inv(r_inv), .o_col(w_res[j]));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_beat    <= '0;
      r_work    <= '0;
      r_out     <= '0;
      r_inv     <= 1'b0;
      r_live    <= 1'b0;
      r_out_vld <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_live    <= 1'b1;
      r_out_vld <= (w_next == S_DONE);
      r_busy    <= (w_next == S_BUSY);
      if (flush) begin
        r_beat <= '0;
      end else if (w_accept) begin
        r_work <= in_state;
        r_inv  <= in_inverse;
        r_beat <= '0;
      end else if (r_state == S_BUSY) begin
        r_beat <= (r_beat == LAST) ? 2'd0 : 2'(r_beat + 2'd1);
        for (int j = 0; j < COLS_PER_CYCLE; j++)
          r_out[(int'(r_beat)*COLS_PER_CYCLE + j)*32 +: 32] <= w_res[j];
      end
    end
  end
endmodule

// File: tb/tb_mix_columns_engine.sv
// Scoreboard bench: three engines (1, 2 and 4 columns per cycle) against a GF(2^8) matrix model.

module tb_mix_columns_engine;
  logic         clk = 1'b0;
  logic         rst;
  logic [2:0]   flush, in_valid, in_inverse, out_ready;
  wire  [2:0]   in_ready, out_valid, busy;
  logic [127:0] in_state [3];
  wire  [127:0] out_state [3];

  int checks = 0;
  int fails  = 0;

  logic [127:0] q0 [$];
  logic [127:0] q1 [$];
  logic [127:0] q2 [$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int CPC = (g == 0) ? 1 : (g == 1) ? 2 : 4;
    mix_columns_engine #(.COLS_PER_CYCLE(CPC)) u_dut (
      .clk(clk), .rst(rst), .flush(flush[g]),
      .in_valid(in_valid[g]), .in_ready(in_ready[g]),
      .in_state(in_state[g]), .in_inverse(in_inverse[g]),
      .out_valid(out_valid[g]), .out_ready(out_ready[g]),
      .out_state(out_state[g]), .busy(busy[g])
    );
  end

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [127:0] ref_mc(input logic [127:0] s, input bit inv);
    logic [7:0]   base [4];
    logic [7:0]   acc;
    logic [127:0] r = '0;
    if (inv) begin base[0] = 8'h0e; base[1] = 8'h0b; base[2] = 8'h0d; base[3] = 8'h09; end
    else     begin base[0] = 8'h02; base[1] = 8'h03; base[2] = 8'h01; base[3] = 8'h01; end
    for (int c = 0; c < 4; c++)
      for (int row = 0; row < 4; row++) begin
        acc = 8'h00;
        for (int i = 0; i < 4; i++)
          acc = acc ^ gmul(base[(i - row + 4) % 4], s[32*c+31-8*i -: 8]);
        r[32*c+31-8*row -: 8] = acc;
      end
    return r;
  endfunction

  function automatic int beats(input int g);
    return (g == 0) ? 4 : (g == 1) ? 2 : 1;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic push(input int g, input logic [127:0] v);
    case (g)
      0:       q0.push_back(v);
      1:       q1.push_back(v);
      default: q2.push_back(v);
    endcase
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (rst) begin
        for (int g = 0; g < 3; g++) begin
          if (out_valid[g] && out_ready[g]) begin
            logic [127:0] e;
            bit           ok;
            ok = 1'b1;
            case (g)
              0:       if (q0.size() > 0) e = q0.pop_front(); else ok = 1'b0;
              1:       if (q1.size() > 0) e = q1.pop_front(); else ok = 1'b0;
              default: if (q2.size() > 0) e = q2.pop_front(); else ok = 1'b0;
            endcase
            if (ok) chk($sformatf("out_state[%0d]", g), out_state[g], e);
            else begin
              checks++; fails++;
              $display("FAIL unexpected_output[%0d] actual=%h required=none", g, out_state[g]);
            end
          end
        end
      end
    end
  endtask

  // Drives one transaction and returns 1 time unit after the accepting edge.
  task automatic send(input int g, input logic [127:0] s, input bit inv, input bit exp_on);
    int n = 0;
    in_state[g] = s; in_inverse[g] = inv; in_valid[g] = 1'b1;
    @(negedge clk);
    while (!in_ready[g] && n < 50) begin @(negedge clk); n++; end
    if (!in_ready[g]) begin
      checks++; fails++;
      $display("FAIL accept_timeout[%0d] actual=no_accept required=accept", g);
      in_valid[g] = 1'b0;
      return;
    end
    if (exp_on) push(g, ref_mc(s, inv));
    @(posedge clk); #1;
    in_valid[g] = 1'b0;
  endtask

  task automatic lat_chk(input int g, input string nm);
    int lat = 0;
    int bc  = 0;
    while (!out_valid[g] && lat < 20) begin
      if (busy[g]) bc++;
      @(posedge clk); #1;
      lat++;
    end
    chk({nm, "_latency"}, 128'(lat), 128'(beats(g)));
    chk({nm, "_busy_cycles"}, 128'(bc), 128'(beats(g)));
  endtask

  task automatic rt(input int g);
    logic [127:0] x;
    repeat (100) begin
      x = rnd128();
      send(g, x, 1'b0, 1'b1);
      push(g, x);
      send(g, ref_mc(x, 1'b0), 1'b1, 1'b0);
    end
  endtask

  initial begin
    logic [127:0] x, y;
    bit           seen;
    int           n;
    rst = 1'b1; flush = '0; in_valid = '0; in_inverse = '0; out_ready = 3'b111;
    for (int g = 0; g < 3; g++) in_state[g] = '0;
    fork monitor(); join_none
    #2 rst = 1'b0;
    #10;
    chk("reset_out_valid", 128'(out_valid), 128'(0));
    chk("reset_busy", 128'(busy), 128'(0));
    chk("reset_in_ready", 128'(in_ready), 128'(0));
    for (int g = 0; g < 3; g++) chk($sformatf("reset_out_state[%0d]", g), out_state[g], '0);
    #1 rst = 1'b1;
    #1 chk("in_ready_before_edge", 128'(in_ready), 128'(0));
    @(posedge clk); #1;
    chk("in_ready_after_release", 128'(in_ready), 128'(3'b111));

    push(2, 128'hc6c6c6c6_01010101_9fdc589d_8e4da1bc);
    send(2, 128'hc6c6c6c6_01010101_f20a225c_db135345, 1'b0, 1'b0);
    lat_chk(2, "fwd_cpc4");

    push(0, 128'h2d26314c_d4d4d4d5_f20a225c_db135345);
    send(0, 128'h4d7ebdf8_d5d5d7d6_9fdc589d_8e4da1bc, 1'b1, 1'b0);
    lat_chk(0, "inv_cpc1");

    out_ready[1] = 1'b0;
    x = rnd128();
    send(1, x, 1'b0, 1'b1);
    n = 0;
    while (!out_valid[1] && n < 20) begin @(posedge clk); #1; n++; end
    y = rnd128();
    in_state[1] = y; in_inverse[1] = 1'b1; in_valid[1] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("hold_out_valid", 128'(out_valid[1]), 128'(1));
      chk("hold_in_ready", 128'(in_ready[1]), 128'(0));
      chk("hold_out_state", out_state[1], ref_mc(x, 1'b0));
      @(posedge clk); #1;
    end
    out_ready[1] = 1'b1;
    push(1, ref_mc(y, 1'b1));
    @(negedge clk);
    chk("b2b_in_ready", 128'(in_ready[1]), 128'(1));
    @(posedge clk); #1;
    in_valid[1] = 1'b0;
    chk("b2b_busy_after_accept", 128'(busy[1]), 128'(1));
    lat_chk(1, "b2b_cpc2");

    send(0, rnd128(), 1'b0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    flush[0] = 1'b1;
    @(posedge clk); #1;
    flush[0] = 1'b0;
    chk("flush_in_ready", 128'(in_ready[0]), 128'(1));
    chk("flush_busy", 128'(busy[0]), 128'(0));
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (out_valid[0]) seen = 1'b1;
      @(posedge clk); #1;
    end
    chk("flush_no_out_valid", 128'(seen), 128'(0));
    send(0, rnd128(), 1'b1, 1'b1);
    lat_chk(0, "post_flush");

    fork
      rt(0);
      rt(1);
      rt(2);
    join
    repeat (8) @(posedge clk);
    #1;

    send(0, rnd128(), 1'b0, 1'b0);
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    chk("areset_out_valid", 128'(out_valid[0]), 128'(0));
    chk("areset_busy", 128'(busy[0]), 128'(0));
    chk("areset_out_state", out_state[0], '0);
    chk("areset_in_ready", 128'(in_ready), 128'(0));
    #3 rst = 1'b1;
    @(posedge clk); #1;
    chk("areset_release_in_ready", 128'(in_ready), 128'(3'b111));
    for (int g = 0; g < 3; g++) begin
      send(g, rnd128(), g[0], 1'b1);
      lat_chk(g, $sformatf("post_reset%0d", g));
    end

    repeat (6) @(posedge clk);
    #1;
    chk("q0_drained", 128'(q0.size()), 128'(0));
    chk("q1_drained", 128'(q1.size()), 128'(0));
    chk("q2_drained", 128'(q2.size()), 128'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
